// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pool_pkg
// Purpose  : Shared constants, types and helpers for the pooled-tile buffer.
//            Holds the default geometry (channels, element width, tile size),
//            the per-bank occupancy state type and the element offset function
//            that fixes the packed layout of a presented tile.
// Revision : 1.0 - initial release
// ============================================================================
package pool_pkg;

  localparam int c_def_ch     = 3;
  localparam int c_def_dw     = 8;
  localparam int c_def_tile_h = 3;
  localparam int c_def_tile_w = 3;

  // Occupancy of one storage bank: FREE while it can be written, FULL from
  // the beat that completes the tile until the consumer takes it.
  typedef enum logic [0:0] {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_state_e;

  // Bit offset of element (channel c, row r, column k) inside a packed tile
  // of n elements per channel.
  function automatic int elem_off(input int c, input int r, input int k,
                                  input int n, input int tile_w, input int dw);
    return (c * n + r * tile_w + k) * dw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_tile_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : pool_tile_buffer_if
// Purpose  : Beat-in / tile-out handshake bundle of the pooled-tile buffer.
//            in_vld/in_rdy/in_data : one element per channel per beat
//            out_vld/out_rdy/out_tile : one complete tile per handshake
//            wr_idx : raster position of the next accepted beat
//            Modport slave is the buffer side, master the producer/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface pool_tile_buffer_if
  import pool_pkg::*;
#(
  parameter int CH     = c_def_ch,
  parameter int DW     = c_def_dw,
  parameter int TILE_H = c_def_tile_h,
  parameter int TILE_W = c_def_tile_w
);
  localparam int c_n  = TILE_H * TILE_W;
  localparam int c_iw = $clog2(c_n);

  logic                   in_vld;
  logic                   in_rdy;
  logic [CH*DW-1:0]       in_data;
  logic                   out_vld;
  logic                   out_rdy;
  logic [CH*c_n*DW-1:0]   out_tile;
  logic [c_iw-1:0]        wr_idx;

  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_tile, wr_idx
  );

  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_tile, wr_idx
  );

endinterface
`default_nettype wire

// File: rtl/pool_tile_bank.sv
`default_nettype none
// ============================================================================
// Module   : pool_tile_bank
// Purpose  : One tile of storage: CH x TILE_H x TILE_W elements of DW bits.
//            A write stores all CH channels of one beat at raster index i_idx.
// Ports    : clk, rst_n (async, active-low, clears storage)
//            i_we   - write strobe
//            i_idx  - raster index (row*TILE_W + col) of the beat
//            i_data - channel c at [c*DW +: DW]
//            o_tile - packed tile, element (c,r,k) at elem_off(c,r,k,...)
// Revision : 1.0 - initial release
// ============================================================================
module pool_tile_bank
  import pool_pkg::*;
#(
  parameter int CH     = c_def_ch,
  parameter int DW     = c_def_dw,
  parameter int TILE_H = c_def_tile_h,
  parameter int TILE_W = c_def_tile_w
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_we,
  input  logic [$clog2(TILE_H*TILE_W)-1:0]      i_idx,
  input  logic [CH*DW-1:0]                      i_data,
  output logic [CH*TILE_H*TILE_W*DW-1:0]        o_tile
);
  localparam int c_n  = TILE_H * TILE_W;
  localparam int c_iw = $clog2(c_n);

  for (genvar c = 0; c < CH; c++) begin : g_ch
    for (genvar r = 0; r < TILE_H; r++) begin : g_row
      for (genvar k = 0; k < TILE_W; k++) begin : g_col
        localparam int c_idx = r * TILE_W + k;
        logic [DW-1:0] r_elem;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_elem <= '0;
          end else if (i_we && (i_idx == c_iw'(c_idx))) begin
            r_elem <= i_data[c*DW +: DW];
          end
        end

        assign o_tile[elem_off(c, r, k, c_n, TILE_W, DW) +: DW] = r_elem;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pool_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : pool_tile_buffer
// Purpose  : Collects raster-ordered beats (one element per channel) into a
//            complete TILE_H x TILE_W tile and presents it with a valid/ready
//            handshake.
// Ports    : clk    - clock, all state on rising edge
//            rst_n  - asynchronous active-low reset (discards everything)
//            clr    - synchronous abort of the tile being written
//            bus    - pool_tile_buffer_if.slave (beat in, tile out, wr_idx)
// Config   : POOL_TILE_PINGPONG_EN defined   -> two banks; the next tile
//                                               fills while one is presented
//            POOL_TILE_PINGPONG_EN undefined -> single bank; input stalls
//                                               while the tile is presented
// Revision : 1.0 - initial release
// ============================================================================
module pool_tile_buffer
  import pool_pkg::*;
#(
  parameter int CH     = c_def_ch,
  parameter int DW     = c_def_dw,
  parameter int TILE_H = c_def_tile_h,
  parameter int TILE_W = c_def_tile_w
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  pool_tile_buffer_if.slave  bus
);
  localparam int c_n  = TILE_H * TILE_W;
  localparam int c_iw = $clog2(c_n);
  localparam int c_tw = CH * c_n * DW;
`ifdef POOL_TILE_PINGPONG_EN
  localparam int c_nb = 2;
`else
  localparam int c_nb = 1;
`endif

  bank_state_e       r_bank_st     [c_nb];
  bank_state_e       w_bank_st_nxt [c_nb];
  logic [c_iw-1:0]   r_wr_idx;
  logic [c_iw-1:0]   w_wr_idx_nxt;
  logic              w_wsel;
  logic              w_rsel;
  logic              w_in_rdy;
  logic              w_out_vld;
  logic              w_acc;
  logic              w_last;
  logic              w_out_hs;
  logic [c_nb-1:0]   w_bank_we;
  logic [c_tw-1:0]   w_tile [c_nb];
  logic [c_tw-1:0]   w_out_tile;

  // --------------------------------------------------------------------------
  // Bank selection. With two banks, the write pointer advances on each
  // completed tile and the read pointer on each delivered tile, so tiles
  // leave in the order they were written.
  // --------------------------------------------------------------------------
`ifdef POOL_TILE_PINGPONG_EN
  logic r_wsel;
  logic r_rsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wsel <= 1'b0;
      r_rsel <= 1'b0;
    end else begin
      if (w_last) begin
        r_wsel <= ~r_wsel;
      end
      if (w_out_hs) begin
        r_rsel <= ~r_rsel;
      end
    end
  end

  assign w_wsel = r_wsel;
  assign w_rsel = r_rsel;
`else
  assign w_wsel = 1'b0;
  assign w_rsel = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Status decode: ready and valid depend on registered state only.
  // --------------------------------------------------------------------------
  always_comb begin
    w_in_rdy   = 1'b0;
    w_out_vld  = 1'b0;
    w_out_tile = '0;
    for (int b = 0; b < c_nb; b++) begin
      if (w_wsel == 1'(b)) begin
        w_in_rdy = (r_bank_st[b] == BANK_FREE);
      end
      if (w_rsel == 1'(b)) begin
        w_out_vld  = (r_bank_st[b] == BANK_FULL);
        w_out_tile = w_tile[b];
      end
    end
  end

  // clr wins over a beat arriving in the same cycle.
  assign w_acc    = bus.in_vld && w_in_rdy && !clr;
  assign w_last   = w_acc && (r_wr_idx == c_iw'(c_n - 1));
  assign w_out_hs = w_out_vld && bus.out_rdy;

  // --------------------------------------------------------------------------
  // Next state. A completing write and a read handshake always target
  // different banks (one must be FREE, the other FULL), so both apply.
  // --------------------------------------------------------------------------
  always_comb begin
    w_wr_idx_nxt = r_wr_idx;
    if (clr || w_last) begin
      w_wr_idx_nxt = '0;
    end else if (w_acc) begin
      w_wr_idx_nxt = r_wr_idx + c_iw'(1);
    end

    for (int b = 0; b < c_nb; b++) begin
      w_bank_st_nxt[b] = r_bank_st[b];
      w_bank_we[b]     = w_acc && (w_wsel == 1'(b));
      if (w_last && (w_wsel == 1'(b))) begin
        w_bank_st_nxt[b] = BANK_FULL;
      end
      if (w_out_hs && (w_rsel == 1'(b))) begin
        w_bank_st_nxt[b] = BANK_FREE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      for (int b = 0; b < c_nb; b++) begin
        r_bank_st[b] <= BANK_FREE;
      end
    end else begin
      r_wr_idx <= w_wr_idx_nxt;
      for (int b = 0; b < c_nb; b++) begin
        r_bank_st[b] <= w_bank_st_nxt[b];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage banks
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < c_nb; b++) begin : g_bank
    pool_tile_bank #(
      .CH     (CH),
      .DW     (DW),
      .TILE_H (TILE_H),
      .TILE_W (TILE_W)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_we   (w_bank_we[b]),
      .i_idx  (r_wr_idx),
      .i_data (bus.in_data),
      .o_tile (w_tile[b])
    );
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_vld  = w_out_vld;
  assign bus.out_tile = w_out_tile;
  assign bus.wr_idx   = r_wr_idx;

endmodule
`default_nettype wire

// File: tb/tb_pool_tile_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pool_tile_buffer
// Purpose  : Directed self-checking bench for pool_tile_buffer. Instantiates
//            a default-geometry buffer (3ch x 8b, 3x3) and a wide one
//            (4ch x 16b, 2x2). Follows POOL_TILE_PINGPONG_EN for expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pool_tile_buffer;

  localparam int c_n1  = 9;
  localparam int c_tw1 = 3 * c_n1 * 8;
  localparam int c_tw2 = 4 * 4 * 16;
`ifdef POOL_TILE_PINGPONG_EN
  localparam bit c_pp = 1'b1;
`else
  localparam bit c_pp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  logic clr2;
  int   n_checks = 0;
  int   n_errs   = 0;

  always #5 clk = ~clk;

  pool_tile_buffer_if #(.CH(3), .DW(8),  .TILE_H(3), .TILE_W(3)) bus  ();
  pool_tile_buffer_if #(.CH(4), .DW(16), .TILE_H(2), .TILE_W(2)) bus2 ();

  pool_tile_buffer #(.CH(3), .DW(8), .TILE_H(3), .TILE_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  pool_tile_buffer #(.CH(4), .DW(16), .TILE_H(2), .TILE_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr2),
    .bus   (bus2)
  );

  function automatic logic [23:0] mk_beat(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input int i);
    logic [7:0] o;
    o = 8'(i);
    return {b2 + o, b1 + o, b0 + o};
  endfunction

  // Expected tile: byte (c*9 + i) = base_c + i
  function automatic logic [c_tw1-1:0] mk_tile(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2);
    logic [c_tw1-1:0] t;
    logic [7:0]       base [3];
    t       = '0;
    base[0] = b0;
    base[1] = b1;
    base[2] = b2;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < c_n1; i++) begin
        t[(c*c_n1 + i)*8 +: 8] = base[c] + 8'(i);
      end
    end
    return t;
  endfunction

  task automatic beat(input logic [23:0] d);
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    @(posedge clk);
    #1;
    bus.in_vld  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; clr2 = 1'b0;
    bus.in_vld = 1'b0;  bus.in_data = '0;  bus.out_rdy = 1'b0;
    bus2.in_vld = 1'b0; bus2.in_data = '0; bus2.out_rdy = 1'b0;
    #12;
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL reset_out_vld: got %0b want 0", bus.out_vld); end
    n_checks++; if (bus.out_tile !== '0) begin n_errs++; $display("FAIL reset_out_tile: got %h want 0", bus.out_tile); end
    n_checks++; if (bus.wr_idx !== 4'd0) begin n_errs++; $display("FAIL reset_wr_idx: got %0d want 0", bus.wr_idx); end
    @(posedge clk); #3; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_errs++; $display("FAIL reset_in_rdy: got %0b want 1", bus.in_rdy); end
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL reset_out_vld_rel: got %0b want 0", bus.out_vld); end
    n_checks++; if (bus2.in_rdy !== 1'b1) begin n_errs++; $display("FAIL reset_in_rdy2: got %0b want 1", bus2.in_rdy); end
  endtask

  task automatic test_basic();
    logic [c_tw1-1:0] exp;
    exp = mk_tile(8'h10, 8'h20, 8'h30);
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_checks++; if (bus.wr_idx !== 4'(i)) begin n_errs++; $display("FAIL basic_wr_idx[%0d]: got %0d want %0d", i, bus.wr_idx, i); end
      n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL basic_early_vld[%0d]: got %0b want 0", i, bus.out_vld); end
      beat(mk_beat(8'h10, 8'h20, 8'h30, i));
    end
    n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL basic_out_vld: got %0b want 1", bus.out_vld); end
    n_checks++; if (bus.out_tile !== exp) begin n_errs++; $display("FAIL basic_tile: got %h want %h", bus.out_tile, exp); end
    n_checks++; if (bus.out_tile[79:72] !== 8'h20) begin n_errs++; $display("FAIL basic_byte9: got %h want 20", bus.out_tile[79:72]); end
    n_checks++; if (bus.out_tile[215:208] !== 8'h38) begin n_errs++; $display("FAIL basic_byte26: got %h want 38", bus.out_tile[215:208]); end
    n_checks++; if (bus.wr_idx !== 4'd0) begin n_errs++; $display("FAIL basic_wrap: got %0d want 0", bus.wr_idx); end
    @(posedge clk); #1;
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL basic_vld_fall: got %0b want 0", bus.out_vld); end
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_errs++; $display("FAIL basic_in_rdy: got %0b want 1", bus.in_rdy); end
  endtask

  task automatic test_backpressure();
    logic [c_tw1-1:0] exp1;
    logic [c_tw1-1:0] exp2;
    logic             exp_rdy;
    int               acc;
    exp1 = mk_tile(8'h41, 8'h42, 8'h43);
    exp2 = mk_tile(8'h51, 8'h52, 8'h53);
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++) beat(mk_beat(8'h41, 8'h42, 8'h43, i));
    n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL bp_out_vld: got %0b want 1", bus.out_vld); end
    acc = 0;
    for (int k = 0; k < 20; k++) begin
      bus.in_vld  = 1'b1;
      bus.in_data = mk_beat(8'h51, 8'h52, 8'h53, acc);
      @(posedge clk); #1;
      if (c_pp && acc < 9) acc++;
      exp_rdy = c_pp && (acc < 9);
      n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL bp_hold_vld[%0d]: got %0b want 1", k, bus.out_vld); end
      n_checks++; if (bus.out_tile !== exp1) begin n_errs++; $display("FAIL bp_hold_tile[%0d]: got %h want %h", k, bus.out_tile, exp1); end
      n_checks++; if (bus.in_rdy !== exp_rdy) begin n_errs++; $display("FAIL bp_in_rdy[%0d]: got %0b want %0b", k, bus.in_rdy, exp_rdy); end
      n_checks++; if (bus.wr_idx !== 4'(acc % 9)) begin n_errs++; $display("FAIL bp_wr_idx[%0d]: got %0d want %0d", k, bus.wr_idx, acc % 9); end
    end
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
`ifdef POOL_TILE_PINGPONG_EN
    n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL bp_second_vld: got %0b want 1", bus.out_vld); end
    n_checks++; if (bus.out_tile !== exp2) begin n_errs++; $display("FAIL bp_second_tile: got %h want %h", bus.out_tile, exp2); end
    @(posedge clk); #1;
`endif
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL bp_vld_fall: got %0b want 0", bus.out_vld); end
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_errs++; $display("FAIL bp_rdy_back: got %0b want 1", bus.in_rdy); end
  endtask

  task automatic test_clr();
    logic [c_tw1-1:0] exp;
    int               presented;
    exp         = {27{8'hAA}};
    presented   = 0;
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) beat(mk_beat(8'h77, 8'h77, 8'h77, i));
    n_checks++; if (bus.wr_idx !== 4'd5) begin n_errs++; $display("FAIL clr_pre_idx: got %0d want 5", bus.wr_idx); end
    clr = 1'b1; bus.in_vld = 1'b1; bus.in_data = 24'h666666;
    @(posedge clk); #1;
    clr = 1'b0; bus.in_vld = 1'b0;
    n_checks++; if (bus.wr_idx !== 4'd0) begin n_errs++; $display("FAIL clr_idx: got %0d want 0", bus.wr_idx); end
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL clr_no_vld: got %0b want 0", bus.out_vld); end
    for (int i = 0; i < 9; i++) begin
      beat(24'hAAAAAA);
      if (bus.out_vld === 1'b1) presented++;
    end
    n_checks++; if (bus.out_tile !== exp) begin n_errs++; $display("FAIL clr_tile: got %h want %h", bus.out_tile, exp); end
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.out_vld === 1'b1) presented++;
    end
    n_checks++; if (presented !== 1) begin n_errs++; $display("FAIL clr_tiles_presented: got %0d want 1", presented); end
  endtask

`ifdef POOL_TILE_PINGPONG_EN
  task automatic test_back_to_back();
    logic [c_tw1-1:0] exp2;
    exp2 = mk_tile(8'h62, 8'h62, 8'h62);
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++) beat(mk_beat(8'h61, 8'h61, 8'h61, i));
    for (int i = 0; i < 8; i++) beat(mk_beat(8'h62, 8'h62, 8'h62, i));
    bus.out_rdy = 1'b1;
    bus.in_vld  = 1'b1;
    bus.in_data = mk_beat(8'h62, 8'h62, 8'h62, 8);
    @(posedge clk); #1;
    bus.in_vld  = 1'b0;
    bus.out_rdy = 1'b0;
    n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL b2b_vld: got %0b want 1", bus.out_vld); end
    n_checks++; if (bus.out_tile !== exp2) begin n_errs++; $display("FAIL b2b_tile: got %h want %h", bus.out_tile, exp2); end
    n_checks++; if (bus.wr_idx !== 4'd0) begin n_errs++; $display("FAIL b2b_wr_idx: got %0d want 0", bus.wr_idx); end
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_errs++; $display("FAIL b2b_in_rdy: got %0b want 1", bus.in_rdy); end
    bus.out_rdy = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL b2b_drain: got %0b want 0", bus.out_vld); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [3:0] exp_idx;
    bus.out_rdy = 1'b0;
    for (int i = 0; i < 9; i++) beat(mk_beat(8'h71, 8'h72, 8'h73, i));
    for (int i = 0; i < 4; i++) beat(mk_beat(8'h81, 8'h82, 8'h83, i));
    exp_idx = c_pp ? 4'd4 : 4'd0;
    n_checks++; if (bus.wr_idx !== exp_idx) begin n_errs++; $display("FAIL rstmid_pre_idx: got %0d want %0d", bus.wr_idx, exp_idx); end
    n_checks++; if (bus.out_vld !== 1'b1) begin n_errs++; $display("FAIL rstmid_pre_vld: got %0b want 1", bus.out_vld); end
    #3; rst_n = 1'b0; #1;
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL rstmid_vld: got %0b want 0", bus.out_vld); end
    n_checks++; if (bus.out_tile !== '0) begin n_errs++; $display("FAIL rstmid_tile: got %h want 0", bus.out_tile); end
    n_checks++; if (bus.wr_idx !== 4'd0) begin n_errs++; $display("FAIL rstmid_idx: got %0d want 0", bus.wr_idx); end
    #2; rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.in_rdy !== 1'b1) begin n_errs++; $display("FAIL rstmid_in_rdy: got %0b want 1", bus.in_rdy); end
    n_checks++; if (bus.out_vld !== 1'b0) begin n_errs++; $display("FAIL rstmid_vld_after: got %0b want 0", bus.out_vld); end
  endtask

  task automatic test_wide_tile();
    logic [c_tw2-1:0] exp;
    logic [15:0]      o;
    exp = 256'hA303_A302_A301_A300_A203_A202_A201_A200_A103_A102_A101_A100_A003_A002_A001_A000;
    bus2.out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus2.wr_idx !== 2'(i)) begin n_errs++; $display("FAIL wide_wr_idx[%0d]: got %0d want %0d", i, bus2.wr_idx, i); end
      o            = 16'(i);
      bus2.in_vld  = 1'b1;
      bus2.in_data = {16'hA300 + o, 16'hA200 + o, 16'hA100 + o, 16'hA000 + o};
      @(posedge clk); #1;
      bus2.in_vld  = 1'b0;
    end
    n_checks++; if (bus2.out_vld !== 1'b1) begin n_errs++; $display("FAIL wide_vld: got %0b want 1", bus2.out_vld); end
    n_checks++; if (bus2.out_tile !== exp) begin n_errs++; $display("FAIL wide_tile: got %h want %h", bus2.out_tile, exp); end
    n_checks++; if (bus2.wr_idx !== 2'd0) begin n_errs++; $display("FAIL wide_wrap: got %0d want 0", bus2.wr_idx); end
    @(posedge clk); #1;
    n_checks++; if (bus2.out_vld !== 1'b0) begin n_errs++; $display("FAIL wide_vld_fall: got %0b want 0", bus2.out_vld); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clr();
`ifdef POOL_TILE_PINGPONG_EN
    test_back_to_back();
`endif
    test_reset_mid();
    test_wide_tile();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/pool_tile_buffer.md
POOL_TILE_BUFFER -- requirements
Module: pool_tile_buffer

Interface
REQ-001 SHALL have parameter CH, default 3, meaning channels written per input beat.
REQ-002 SHALL have parameter DW, default 8, meaning bits per pooled element.
REQ-003 SHALL have parameter TILE_H, default 3, meaning tile rows.
REQ-004 SHALL have parameter TILE_W, default 3, meaning tile columns; N = TILE_H*TILE_W, min 2.
REQ-005 SHALL have port clk, input, 1, meaning clock, all state on rising edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port clr, input, 1, meaning synchronous abort of tile in progress.
REQ-008 SHALL have port in_vld, input, 1, meaning in_data valid.
REQ-009 SHALL have port in_rdy, output, 1, meaning buffer accepts a beat this cycle.
REQ-010 SHALL have port in_data, input, CH*DW, meaning one element per channel; channel c at bits [c*DW +: DW].
REQ-011 SHALL have port out_vld, output, 1, meaning complete tile presented.
REQ-012 SHALL have port out_rdy, input, 1, meaning consumer takes tile.
REQ-013 SHALL have port out_tile, output, CH*N*DW, meaning element (c,r,k) at bits [(c*N + r*TILE_W + k)*DW +: DW].
REQ-014 SHALL have port wr_idx, output, clog2(N), meaning raster position of next accepted beat.

Function
REQ-015 Beat accepted when in_vld && in_rdy; written to raster position wr_idx of the write bank, all CH channels in the same cycle.
REQ-016 wr_idx increments by 1 per accepted beat; wraps N-1 -> 0 on the beat that completes a tile.
REQ-017 Beat at wr_idx==N-1 marks the write bank full; out_vld rises the next cycle (latency 1 from last beat).
REQ-018 out_tile and out_vld hold stable while out_vld && !out_rdy; no element changes under a presented tile.
REQ-019 Handshake out_vld && out_rdy frees the read bank; out_vld falls the next cycle unless another full bank is pending.
REQ-020 in_rdy is low when no bank is free; in_vld while !in_rdy is ignored, wr_idx unchanged.
REQ-021 in_rdy is combinational from state only, never from in_vld or out_rdy.
REQ-022 Completing write and read handshake in the same cycle SHALL both take effect; no tile lost or duplicated.
REQ-023 clr forces wr_idx to 0 and discards the partial tile; a full/presented tile is kept; clr has priority over a same-cycle beat.
REQ-024 Storage content not cleared by clr; out_tile of non-presented banks is don't-care.

Reset
REQ-025 On rst_n low: wr_idx=0, all banks empty, out_vld=0, out_tile=0, in_rdy=1 after release; reset mid-tile discards all data.

Configuration
REQ-026 Macro POOL_TILE_PINGPONG_EN defined: two banks; writes alternate banks; in_rdy=1 unless both full; tile k+1 fills while tile k is presented; tiles delivered in write order.
REQ-027 POOL_TILE_PINGPONG_EN undefined: one bank; in_rdy=0 from full until cycle after out handshake; same ports and timing otherwise.

Structure
REQ-028 Shared package pool_pkg SHALL hold default CH/DW/TILE_H/TILE_W constants and the element-offset function used by REQ-013.
REQ-029 One sub-module pool_tile_bank (CH*N*DW register array, write-enable, raster index) SHALL be instantiated once or twice per REQ-026/027.

Verification
REQ-030 Defaults, 9 beats value 0x10+i on ch0, 0x20+i ch1, 0x30+i ch2, out_rdy=1 -> out_vld one cycle after beat 8; out_tile byte (c*9+i) = 0x10*(c+1)+i.
REQ-031 out_rdy=0 for 20 cycles after full -> out_tile stable; without macro in_rdy=0 throughout; with macro 9 more beats accepted, then in_rdy=0.
REQ-032 clr at wr_idx=5 then 9 beats of 0xAA -> only one tile presented, all bytes 0xAA.
REQ-033 Macro on: last beat of tile 2 same cycle as out handshake of tile 1 -> tile 2 presented next cycle, no drop, wr_idx=0.
REQ-034 rst_n asserted at wr_idx=4 with a tile presented -> out_vld=0, out_tile=0, wr_idx=0 immediately, asynchronously.
REQ-035 CH=4, DW=16, TILE_H=2, TILE_W=2 -> 4 beats form one 256-bit tile at the packed offsets of REQ-013.
